// File: rtl/sd_block_reader.sv
// Single-block (CMD17) SD read sequencer: issues the command, checks R1, polls for the start
// token, then streams 512 data bytes into an external RAM and discards the two CRC bytes.
module sd_block_reader #(
  parameter bit          BLOCK_ADDR    = 1'b1,
  parameter int unsigned TOKEN_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        res,
  input  logic        sd_ready,
  input  logic        rd_req,
  input  logic [31:0] rd_addr,
  output logic        rd_busy,
  output logic        rd_done,
  output logic        rd_error,
  output logic [2:0]  err_code,
  output logic        wr_en,
  output logic [8:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        spi_cmd,
  output logic [47:0] spi_cmd_data,
  output logic [9:0]  spi_response_len,
  input  logic        spi_busy,
  input  logic        spi_error,
  input  logic [7:0]  spi_response,
  input  logic        spi_avail
);

  localparam int unsigned PollW = $clog2(TOKEN_TIMEOUT + 1);

  localparam logic [2:0] ErrSpi      = 3'd1;
  localparam logic [2:0] ErrR1       = 3'd2;
  localparam logic [2:0] ErrTimeout  = 3'd3;
  localparam logic [2:0] ErrToken    = 3'd4;
  localparam logic [2:0] ErrNotReady = 3'd5;

  typedef enum logic [3:0] {
    StIdle, StSendCmd, StWaitR1, StSendPoll, StWaitToken, StSendData, StRecvData, StDone, StError
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [PollW-1:0]   poll_cnt_q, poll_cnt_d;
  logic [9:0]         byte_cnt_q, byte_cnt_d;
  logic               busy_q, busy_d;
  logic [2:0]         err_code_q, err_code_d;
  logic               wr_en_q, wr_en_d;
  logic [8:0]         wr_addr_q, wr_addr_d;
  logic [7:0]         wr_data_q, wr_data_d;
  logic [31:0]        cmd_arg;

  // SDSC cards take a byte address; bits above 22 fall off the 32-bit argument.
  assign cmd_arg = BLOCK_ADDR ? addr_q : {addr_q[22:0], 9'b0};

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      poll_cnt_q <= '0;
      byte_cnt_q <= '0;
      busy_q     <= 1'b0;
      err_code_q <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      poll_cnt_q <= poll_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      busy_q     <= busy_d;
      err_code_q <= err_code_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    poll_cnt_d       = poll_cnt_q;
    byte_cnt_d       = byte_cnt_q;
    busy_d           = busy_q;
    err_code_d       = err_code_q;
    wr_en_d          = 1'b0;
    wr_addr_d        = wr_addr_q;
    wr_data_d        = wr_data_q;
    spi_cmd          = 1'b0;
    spi_cmd_data     = '0;
    spi_response_len = '0;
    rd_done          = 1'b0;
    rd_error         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rd_req) begin
          if (!sd_ready) begin
            err_code_d = ErrNotReady;
            state_d    = StError;
          end else if (!spi_busy) begin
            addr_d     = rd_addr;
            busy_d     = 1'b1;
            err_code_d = '0;
            poll_cnt_d = '0;
            byte_cnt_d = '0;
            state_d    = StSendCmd;
          end
        end
      end
      StSendCmd: begin
        spi_cmd_data     = {8'h51, cmd_arg, 8'hFF};
        spi_response_len = 10'd1;
        if (!spi_busy) begin
          spi_cmd = 1'b1;
          state_d = StWaitR1;
        end
      end
      StWaitR1: begin
        if (spi_avail) begin
          if (spi_response == 8'h00) begin
            state_d = StSendPoll;
          end else begin
            err_code_d = ErrR1;
            state_d    = StError;
          end
        end
      end
      StSendPoll: begin
        spi_cmd_data     = '1;
        spi_response_len = 10'd1;
        if (!spi_busy) begin
          spi_cmd    = 1'b1;
          poll_cnt_d = poll_cnt_q + PollW'(1);
          state_d    = StWaitToken;
        end
      end
      StWaitToken: begin
        if (spi_avail) begin
          if (spi_response == 8'hFE) begin
            state_d = StSendData;
          end else if (spi_response[7:4] == 4'h0) begin
            err_code_d = ErrToken;
            state_d    = StError;
          end else if (poll_cnt_q == PollW'(TOKEN_TIMEOUT)) begin
            err_code_d = ErrTimeout;
            state_d    = StError;
          end else begin
            state_d = StSendPoll;
          end
        end
      end
      StSendData: begin
        spi_cmd_data     = '1;
        spi_response_len = 10'd514;
        if (!spi_busy) begin
          spi_cmd    = 1'b1;
          byte_cnt_d = '0;
          state_d    = StRecvData;
        end
      end
      StRecvData: begin
        if (spi_avail) begin
          if (byte_cnt_q < 10'd512) begin
            wr_en_d   = 1'b1;
            wr_addr_d = byte_cnt_q[8:0];
            wr_data_d = spi_response;
          end
          if (byte_cnt_q == 10'd513) state_d = StDone;
          byte_cnt_d = byte_cnt_q + 10'd1;
        end
      end
      StDone: begin
        rd_done = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      StError: begin
        rd_error = 1'b1;
        busy_d   = 1'b0;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Engine fault wins over anything decoded above, including a same-cycle byte.
    if (spi_error && !(state_q inside {StIdle, StDone, StError})) begin
      state_d    = StError;
      err_code_d = ErrSpi;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      poll_cnt_d = poll_cnt_q;
      byte_cnt_d = byte_cnt_q;
      spi_cmd    = 1'b0;
    end
  end

  assign rd_busy  = busy_q;
  assign err_code = err_code_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_sd_block_reader.sv
// Bench for sd_block_reader: a scripted SPI engine/card, a transaction model that derives the
// expected commands, RAM writes and outcome, and one per-cycle compare process.
module tb_sd_block_reader;

  localparam int unsigned To = 8;

  logic        clk, res, sd_ready, rd_req;
  logic [31:0] rd_addr;
  logic        spi_busy, spi_error, spi_avail;
  logic [7:0]  spi_response;
  logic        rd_busy, rd_done, rd_error, wr_en, spi_cmd;
  logic [2:0]  err_code;
  logic [8:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [47:0] spi_cmd_data;
  logic [9:0]  spi_response_len;
  logic        b_rd_busy, b_rd_done, b_rd_error, b_wr_en, b_spi_cmd;
  logic [2:0]  b_err_code;
  logic [8:0]  b_wr_addr;
  logic [7:0]  b_wr_data;
  logic [47:0] b_spi_cmd_data;
  logic [9:0]  b_spi_response_len;

  sd_block_reader #(.BLOCK_ADDR(1'b1), .TOKEN_TIMEOUT(To)) dut (
    .clk(clk), .res(res), .sd_ready(sd_ready), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_busy(rd_busy), .rd_done(rd_done), .rd_error(rd_error), .err_code(err_code),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .spi_cmd(spi_cmd),
    .spi_cmd_data(spi_cmd_data), .spi_response_len(spi_response_len), .spi_busy(spi_busy),
    .spi_error(spi_error), .spi_response(spi_response), .spi_avail(spi_avail)
  );

  // Byte-addressed twin, driven identically; only its command argument is inspected.
  sd_block_reader #(.BLOCK_ADDR(1'b0), .TOKEN_TIMEOUT(To)) dut_b (
    .clk(clk), .res(res), .sd_ready(sd_ready), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_busy(b_rd_busy), .rd_done(b_rd_done), .rd_error(b_rd_error), .err_code(b_err_code),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .spi_cmd(b_spi_cmd),
    .spi_cmd_data(b_spi_cmd_data), .spi_response_len(b_spi_response_len),
    .spi_busy(spi_busy), .spi_error(spi_error), .spi_response(spi_response),
    .spi_avail(spi_avail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Plan written by the stimulus thread only.
  int          plan_seq = 0;
  int          err_at = -1;
  logic [7:0]  resp_arr [0:1023];
  logic [47:0] exp_cmd [0:15];
  logic [9:0]  exp_len [0:15];
  logic [7:0]  exp_wr [0:511];
  int          exp_cmd_n, exp_wr_n;
  logic [2:0]  exp_code;
  int          pin_polls, pin_wr_n, pin_last_wr, pin_ram_seed;
  bit          pin_cmd_v, pin_b_v;
  logic [47:0] pin_cmd, pin_b;

  // Written by the compare process only.
  int n_pass = 0, n_total = 0, done_seq = 0;
  logic [7:0] mem [0:511];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Transaction model: what the card sends and what the reader must do about it.
  task automatic plan(input logic [31:0] addr, input logic [7:0] r1, input int n_fill,
                      input logic [7:0] fill, input logic [7:0] tok, input int e_at,
                      input int seed);
    int p, nr, nw;
    logic [7:0] b;
    nr = 0;
    err_at = e_at;
    exp_cmd[0] = {8'h51, addr, 8'hFF};
    exp_len[0] = 10'd1;
    exp_cmd_n = 1;
    exp_wr_n = 0;
    resp_arr[nr++] = r1;
    exp_code = 3'd0;
    if (r1 != 8'h00) exp_code = 3'd2;
    else begin
      p = 0;
      while (1) begin
        exp_cmd[exp_cmd_n] = '1;
        exp_len[exp_cmd_n] = 10'd1;
        exp_cmd_n++;
        p++;
        b = (p <= n_fill) ? fill : tok;
        resp_arr[nr++] = b;
        if (b == 8'hFE) break;
        if (b[7:4] == 4'h0) begin exp_code = 3'd4; break; end
        if (p == To) begin exp_code = 3'd3; break; end
      end
      if (exp_code == 3'd0) begin
        exp_cmd[exp_cmd_n] = '1;
        exp_len[exp_cmd_n] = 10'd514;
        exp_cmd_n++;
        for (int i = 0; i < 514; i++) resp_arr[nr++] = (i < 512) ? 8'(i + seed) : 8'hC3;
        nw = (e_at >= 0) ? e_at : 512;
        if (e_at >= 0) exp_code = 3'd1;
        for (int i = 0; i < nw; i++) exp_wr[i] = 8'(i + seed);
        exp_wr_n = nw;
      end
    end
    plan_seq++;
  endtask

  task automatic plan_fixed(input logic [2:0] code);
    exp_cmd_n = 0;
    exp_wr_n = 0;
    exp_code = code;
    err_at = -1;
    plan_seq++;
  endtask

  task automatic clear_pins();
    pin_polls = -1; pin_wr_n = -1; pin_last_wr = -1; pin_ram_seed = -1;
    pin_cmd_v = 1'b0; pin_b_v = 1'b0; pin_cmd = '0; pin_b = '0;
  endtask

  // SPI engine/card: busy for the command, then one byte per cycle, then one idle-busy cycle.
  initial begin : engine
    int idx, seen, len;
    spi_busy = 1'b0; spi_error = 1'b0; spi_avail = 1'b0; spi_response = 8'h00;
    idx = 0; seen = 0;
    forever begin
      @(negedge clk);
      if (plan_seq != seen) begin idx = 0; seen = plan_seq; end
      if (spi_cmd && !res) begin
        len = int'(spi_response_len);
        @(posedge clk); #1 spi_busy = 1'b1;
        repeat (2) @(posedge clk);
        for (int i = 0; i < len; i++) begin
          @(posedge clk); #1;
          if (res) break;
          spi_avail = 1'b1;
          spi_response = resp_arr[idx];
          idx++;
          if (len == 514 && i == err_at) begin spi_error = 1'b1; break; end
        end
        @(posedge clk); #1 spi_avail = 1'b0; spi_error = 1'b0;
        @(posedge clk); #1 spi_busy = 1'b0;
      end
    end
  end

  initial begin : compare
    int seen, cmd_i, wr_i, polls, last_wr, bad;
    bit b_seen, post;
    logic [47:0] first_cmd, b_first;
    seen = 0; cmd_i = 0; wr_i = 0; polls = 0; last_wr = -1; b_seen = 0; post = 0;
    first_cmd = '0; b_first = '0;
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    forever begin
      @(negedge clk);
      if (plan_seq != seen) begin
        seen = plan_seq; cmd_i = 0; wr_i = 0; polls = 0; last_wr = -1; b_seen = 0;
        first_cmd = '0; b_first = '0;
      end
      if (post) begin
        chk("busy_after_exit", 96'(rd_busy), 96'(0));
        post = 0;
      end
      if (res) begin
        chk("outputs_in_reset", 96'({rd_busy, rd_done, rd_error, err_code, wr_en, wr_addr,
            wr_data, spi_cmd, spi_cmd_data, spi_response_len}), 96'(0));
      end else begin
        if (spi_cmd) begin
          chk("cmd_while_engine_busy", 96'(spi_busy), 96'(0));
          chk("busy_during_read", 96'(rd_busy), 96'(1));
          if (cmd_i == 0) first_cmd = spi_cmd_data;
          if (spi_cmd_data == '1 && spi_response_len == 10'd1) polls++;
          if (cmd_i < exp_cmd_n) begin
            chk("cmd_data", 96'(spi_cmd_data), 96'(exp_cmd[cmd_i]));
            chk("cmd_len", 96'(spi_response_len), 96'(exp_len[cmd_i]));
          end else chk("cmd_extra", 96'(cmd_i + 1), 96'(exp_cmd_n));
          cmd_i++;
        end
        if (b_spi_cmd && !b_seen) begin b_first = b_spi_cmd_data; b_seen = 1; end
        if (wr_en) begin
          if (wr_i < exp_wr_n) begin
            chk("wr_addr", 96'(wr_addr), 96'(wr_i));
            chk("wr_data", 96'(wr_data), 96'(exp_wr[wr_i]));
          end else chk("wr_extra", 96'(wr_i + 1), 96'(exp_wr_n));
          mem[wr_addr] = wr_data;
          last_wr = int'(wr_addr);
          wr_i++;
        end
        if (rd_done || rd_error) begin
          chk("result", 96'({rd_done, rd_error, err_code}),
              96'({exp_code == 3'd0, exp_code != 3'd0, exp_code}));
          chk("cmd_count", 96'(cmd_i), 96'(exp_cmd_n));
          chk("wr_count", 96'(wr_i), 96'(exp_wr_n));
          if (pin_polls >= 0) chk("pin_polls", 96'(polls), 96'(pin_polls));
          if (pin_wr_n >= 0) chk("pin_wr_total", 96'(wr_i), 96'(pin_wr_n));
          if (pin_last_wr >= 0) chk("pin_last_wr_addr", 96'(last_wr), 96'(pin_last_wr));
          if (pin_cmd_v) chk("pin_cmd17", 96'(first_cmd), 96'(pin_cmd));
          if (pin_b_v) chk("pin_cmd17_byte_addr", 96'(b_first), 96'(pin_b));
          if (pin_ram_seed >= 0) begin
            bad = 0;
            for (int i = 0; i < 512; i++) if (mem[i] !== 8'(i + pin_ram_seed)) bad++;
            chk("ram_contents_bad", 96'(bad), 96'(0));
          end
          done_seq = plan_seq;
          post = 1;
        end
      end
    end
  end

  task automatic do_read(input logic [31:0] a, input bit disturb);
    @(posedge clk); #1 rd_addr = a; rd_req = 1'b1;
    @(posedge clk); #1 rd_req = 1'b0; rd_addr = 32'hDEAD_BEEF;
    if (disturb) begin
      repeat (20) @(posedge clk);
      #1 sd_ready = 1'b0; rd_req = 1'b1;
      @(posedge clk); #1 rd_req = 1'b0;
      repeat (5) @(posedge clk);
      #1 sd_ready = 1'b1;
    end
    for (int k = 0; k < 3000 && done_seq != plan_seq; k++) @(posedge clk);
    if (done_seq != plan_seq) begin
      $display("FAIL read_timeout: got no completion, expected rd_done or rd_error");
      $fatal(1, "read did not complete");
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin : stimulus
    res = 1'b1; sd_ready = 1'b1; rd_req = 1'b0; rd_addr = '0;
    clear_pins();
    repeat (3) @(posedge clk);
    #1 res = 1'b0;
    repeat (2) @(posedge clk);

    // Full block read, with rd_req and sd_ready disturbed mid-read.
    clear_pins();
    pin_polls = 4; pin_wr_n = 512; pin_ram_seed = 0; pin_last_wr = 511;
    pin_cmd_v = 1'b1; pin_cmd = 48'h51_0000_1234_FF;
    pin_b_v = 1'b1; pin_b = 48'h51_0024_6800_FF;
    plan(32'h1234, 8'h00, 3, 8'hFF, 8'hFE, -1, 0);
    do_read(32'h1234, 1'b1);

    // Bad R1; byte-addressed argument of the twin.
    clear_pins();
    pin_wr_n = 0; pin_polls = 0;
    pin_cmd_v = 1'b1; pin_cmd = 48'h51_0000_0003_FF;
    pin_b_v = 1'b1; pin_b = 48'h51_0000_0600_FF;
    plan(32'd3, 8'h04, 0, 8'hFF, 8'hFE, -1, 0);
    do_read(32'd3, 1'b0);

    // Token timeout.
    clear_pins();
    pin_polls = 8; pin_wr_n = 0;
    plan(32'd77, 8'h00, 100, 8'hFF, 8'hFE, -1, 0);
    do_read(32'd77, 1'b0);

    // Data error token.
    clear_pins();
    pin_polls = 2;
    plan(32'd5, 8'h00, 1, 8'hFF, 8'h09, -1, 0);
    do_read(32'd5, 1'b0);

    // Engine fault on data byte 100, same cycle as spi_avail.
    clear_pins();
    pin_wr_n = 100; pin_last_wr = 99;
    plan(32'd6, 8'h00, 0, 8'hFF, 8'hFE, 100, 8'h40);
    do_read(32'd6, 1'b0);

    // Request while not ready.
    clear_pins();
    sd_ready = 1'b0;
    plan_fixed(3'd5);
    do_read(32'd8, 1'b0);
    sd_ready = 1'b1;

    // Non-token filler bytes count as idle polls; address above 2^23 in block mode.
    clear_pins();
    pin_polls = 3; pin_wr_n = 512;
    pin_cmd_v = 1'b1; pin_cmd = 48'h51_ABCD_EF01_FF;
    plan(32'hABCD_EF01, 8'h00, 2, 8'hA5, 8'hFE, -1, 7);
    do_read(32'hABCD_EF01, 1'b0);

    // Reset around data byte 300, then a clean read.
    clear_pins();
    plan(32'd9, 8'h00, 0, 8'hFF, 8'hFE, -1, 0);
    @(posedge clk); #1 rd_addr = 32'd9; rd_req = 1'b1;
    @(posedge clk); #1 rd_req = 1'b0;
    for (int k = 0; k < 3000 && !(wr_en && wr_addr == 9'd299); k++) @(posedge clk);
    if (!(wr_en && wr_addr == 9'd299)) begin
      $display("FAIL reach_byte_300: got no write at 299, expected one");
      $fatal(1, "read stalled before byte 300");
    end
    plan_fixed(3'd7);
    #1 res = 1'b1;
    repeat (3) @(posedge clk);
    #1 res = 1'b0;
    repeat (6) @(posedge clk);
    clear_pins();
    pin_wr_n = 512; pin_polls = 1; pin_ram_seed = 8'h55;
    plan(32'd10, 8'h00, 0, 8'hFF, 8'hFE, -1, 8'h55);
    do_read(32'd10, 1'b0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no end of test, expected finish within 50000 cycles");
    $fatal(1, "watchdog");
  end

endmodule
